// File: rtl/gray_decoder_if.sv
// Stream bundle for the Gray-to-binary decoder: the Gray input handshake
// plus the decoded binary output handshake and its sequence status.
interface gray_decoder_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     gray_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     bin_out;
    logic                 step_err;
    logic                 repeat_flag;
    logic                 dir_up;
    logic                 dir_down;
    logic [ERR_CNT_W-1:0] err_count;

    // Upstream/downstream side (the environment driving the decoder)
    modport master (
        output in_valid, gray_in, out_ready,
        input  in_ready, out_valid, bin_out, step_err, repeat_flag,
               dir_up, dir_down, err_count
    );

    // Decoder side
    modport slave (
        input  in_valid, gray_in, out_ready,
        output in_ready, out_valid, bin_out, step_err, repeat_flag,
               dir_up, dir_down, err_count
    );
endinterface

// File: rtl/gray_decoder.sv
// Streaming Gray-to-binary decoder with a registered output stage and a
// sequence checker that flags repeats, multi-bit jumps and step direction.
module gray_decoder #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    gray_decoder_if.slave bus
);

    logic [WIDTH-1:0]     bin_dec;
    logic [WIDTH-1:0]     gray_diff;
    logic                 accept;
    logic                 no_change;
    logic                 one_change;

    logic                 out_valid_reg,   out_valid_next;
    logic [WIDTH-1:0]     bin_out_reg,     bin_out_next;
    logic                 step_err_reg,    step_err_next;
    logic                 repeat_flag_reg, repeat_flag_next;
    logic                 dir_up_reg,      dir_up_next;
    logic                 dir_down_reg,    dir_down_next;
    logic [ERR_CNT_W-1:0] err_count_reg,   err_count_next;
    logic                 have_prev_reg,   have_prev_next;
    logic [WIDTH-1:0]     prev_gray_reg,   prev_gray_next;
    logic [WIDTH-1:0]     prev_bin_reg,    prev_bin_next;

    // Prefix-XOR from the MSB down: each binary bit folds in all higher Gray bits.
    assign bin_dec[WIDTH-1] = bus.gray_in[WIDTH-1];
    generate
        for (genvar gi = WIDTH - 2; gi >= 0; gi--) begin : g_decode
            assign bin_dec[gi] = bin_dec[gi+1] ^ bus.gray_in[gi];
        end
    endgenerate

    // Hamming distance is only needed as 0 / 1 / more, so a one-hot test suffices.
    assign gray_diff  = bus.gray_in ^ prev_gray_reg;
    assign no_change  = (gray_diff == '0);
    assign one_change = !no_change && ((gray_diff & (gray_diff - WIDTH'(1))) == '0);

    assign bus.in_ready = !out_valid_reg || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        out_valid_next   = out_valid_reg;
        bin_out_next     = bin_out_reg;
        step_err_next    = step_err_reg;
        repeat_flag_next = repeat_flag_reg;
        dir_up_next      = dir_up_reg;
        dir_down_next    = dir_down_reg;
        err_count_next   = err_count_reg;
        have_prev_next   = have_prev_reg;
        prev_gray_next   = prev_gray_reg;
        prev_bin_next    = prev_bin_reg;

        if (accept) begin
            out_valid_next   = 1'b1;
            bin_out_next     = bin_dec;
            step_err_next    = 1'b0;
            repeat_flag_next = 1'b0;
            dir_up_next      = 1'b0;
            dir_down_next    = 1'b0;
            have_prev_next   = 1'b1;
            prev_gray_next   = bus.gray_in;
            prev_bin_next    = bin_dec;

            if (have_prev_reg) begin
                if (no_change) begin
                    repeat_flag_next = 1'b1;
                end else if (one_change) begin
                    dir_up_next   = (bin_dec == WIDTH'(prev_bin_reg + WIDTH'(1)));
                    dir_down_next = (bin_dec == WIDTH'(prev_bin_reg - WIDTH'(1)));
                end else begin
                    step_err_next = 1'b1;
                    if (err_count_reg != {ERR_CNT_W{1'b1}})
                        err_count_next = err_count_reg + ERR_CNT_W'(1);
                end
            end
        end else if (out_valid_reg && bus.out_ready) begin
            // Consumed with nothing behind it: drop valid, keep the data fields.
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg   <= 1'b0;
            bin_out_reg     <= '0;
            step_err_reg    <= 1'b0;
            repeat_flag_reg <= 1'b0;
            dir_up_reg      <= 1'b0;
            dir_down_reg    <= 1'b0;
            err_count_reg   <= '0;
            have_prev_reg   <= 1'b0;
            prev_gray_reg   <= '0;
            prev_bin_reg    <= '0;
        end else begin
            out_valid_reg   <= out_valid_next;
            bin_out_reg     <= bin_out_next;
            step_err_reg    <= step_err_next;
            repeat_flag_reg <= repeat_flag_next;
            dir_up_reg      <= dir_up_next;
            dir_down_reg    <= dir_down_next;
            err_count_reg   <= err_count_next;
            have_prev_reg   <= have_prev_next;
            prev_gray_reg   <= prev_gray_next;
            prev_bin_reg    <= prev_bin_next;
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.bin_out     = bin_out_reg;
    assign bus.step_err    = step_err_reg;
    assign bus.repeat_flag = repeat_flag_reg;
    assign bus.dir_up      = dir_up_reg;
    assign bus.dir_down    = dir_down_reg;
    assign bus.err_count   = err_count_reg;

endmodule

// File: tb/tb_gray_decoder.sv
// Directed bench for gray_decoder: two instances share one stimulus stream,
// the second with a 2-bit error counter to exercise saturation.
module tb_gray_decoder;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    gray_decoder_if #(.WIDTH(4), .ERR_CNT_W(8)) bus ();
    gray_decoder_if #(.WIDTH(4), .ERR_CNT_W(2)) bus_sat ();

    gray_decoder #(.WIDTH(4), .ERR_CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    gray_decoder #(.WIDTH(4), .ERR_CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_sat)
    );

    assign bus_sat.in_valid  = bus.in_valid;
    assign bus_sat.gray_in   = bus.gray_in;
    assign bus_sat.out_ready = bus.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.gray_in   = 4'b0000;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Present one word, clock it in, and check the word now on the output.
    task automatic send(input string tag, input logic [3:0] g, input logic [3:0] exp_bin,
                        input logic [3:0] exp_flags, input int exp_err, input int exp_err_sat);
        bus.in_valid = 1'b1;
        bus.gray_in  = g;
        tick();
        check_eq({tag, " valid"}, bus.out_valid, 1);
        check_eq({tag, " bin"},   bus.bin_out, exp_bin);
        // flags packed as {step_err, repeat_flag, dir_up, dir_down}
        check_eq({tag, " flags"}, {bus.step_err, bus.repeat_flag, bus.dir_up, bus.dir_down}, exp_flags);
        check_eq({tag, " err"},     bus.err_count, exp_err);
        check_eq({tag, " err_sat"}, bus_sat.err_count, exp_err_sat);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset state
        do_reset();
        check_eq("rst out_valid", bus.out_valid, 0);
        check_eq("rst bin_out",   bus.bin_out, 0);
        check_eq("rst err_count", bus.err_count, 0);
        check_eq("rst in_ready",  bus.in_ready, 1);
        check_eq("rst flags", {bus.step_err, bus.repeat_flag, bus.dir_up, bus.dir_down}, 0);

        // First word after reset: no flags
        send("first", 4'b1100, 4'b1000, 4'b0000, 0, 0);

        // Back-to-back up-count stream
        do_reset();
        send("up0", 4'b0000, 4'd0, 4'b0000, 0, 0);
        send("up1", 4'b0001, 4'd1, 4'b0010, 0, 0);
        send("up2", 4'b0011, 4'd2, 4'b0010, 0, 0);
        send("up3", 4'b0010, 4'd3, 4'b0010, 0, 0);

        // Wrap-around up then down
        do_reset();
        send("wrap0", 4'b1000, 4'd15, 4'b0000, 0, 0);
        send("wrap1", 4'b0000, 4'd0,  4'b0010, 0, 0);
        send("wrap2", 4'b1000, 4'd15, 4'b0001, 0, 0);

        // Step errors, repeat, saturation of the 2-bit counter
        do_reset();
        send("err0", 4'b0000, 4'd0,  4'b0000, 0, 0);
        send("err1", 4'b0011, 4'd2,  4'b1000, 1, 1);
        send("rep",  4'b0011, 4'd2,  4'b0100, 1, 1);
        send("jmp1", 4'b1100, 4'd8,  4'b1000, 2, 2);
        send("jmp2", 4'b0011, 4'd2,  4'b1000, 3, 3);
        send("jmp3", 4'b1100, 4'd8,  4'b1000, 4, 3);
        send("jmp4", 4'b0011, 4'd2,  4'b1000, 5, 3);
        send("jmp5", 4'b1100, 4'd8,  4'b1000, 6, 3);

        // Backpressure: output must hold and in_ready must drop
        do_reset();
        send("bp0", 4'b0000, 4'd0, 4'b0000, 0, 0);
        bus.out_ready = 1'b0;
        bus.gray_in   = 4'b0001;
        #1;
        check_eq("bp in_ready low", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp hold valid", bus.out_valid, 1);
            check_eq("bp hold bin",   bus.bin_out, 0);
            check_eq("bp in_ready",   bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp release in_ready", bus.in_ready, 1);
        send("bp1", 4'b0001, 4'd1, 4'b0010, 0, 0);
        bus.in_valid = 1'b0;
        tick();
        check_eq("drain valid", bus.out_valid, 0);
        check_eq("drain bin kept", bus.bin_out, 1);

        // Reset while a word is stalled in the output register
        do_reset();
        send("mid0", 4'b0000, 4'd0, 4'b0000, 0, 0);
        send("mid1", 4'b0110, 4'd4, 4'b1000, 1, 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        check_eq("mid stalled valid", bus.out_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid rst valid", bus.out_valid, 0);
        check_eq("mid rst err",   bus.err_count, 0);
        bus.out_ready = 1'b1;
        send("mid first", 4'b0101, 4'd6, 4'b0000, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
